// File: rtl/car_drive_ctl.sv
// Bluetooth car drive controller: command decode, ramped two-motor PWM, link watchdog.
// Optional echo of accepted commands when CAR_ECHO_EN is defined.
module car_drive_ctl #(
   parameter int PWM_DIV   = 4,
   parameter int RAMP_STEP = 8,
   parameter int WDOG_CYC  = 50_000_000,
   parameter int DEF_SPEED = 5
) (
   input  logic       clk_rx,
   input  logic       rst_clk_rx_n,
   input  logic [7:0] rx_data,
   input  logic       rx_data_rdy,
   input  logic       char_fifo_full,
   output logic       mot_l_pwm,
   output logic       mot_l_dir,
   output logic       mot_r_pwm,
   output logic       mot_r_dir,
   output logic [2:0] drv_state,
   output logic [3:0] cur_speed,
   output logic       cmd_err,
   output logic       wdog_trip,
   output logic       send_char_val,
   output logic [7:0] send_char
);

   localparam logic [2:0] ST_STOP  = 3'd0;
   localparam logic [2:0] ST_FWD   = 3'd1;
   localparam logic [2:0] ST_REV   = 3'd2;
   localparam logic [2:0] ST_LEFT  = 3'd3;
   localparam logic [2:0] ST_RIGHT = 3'd4;

   localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam int WW = $clog2(WDOG_CYC);
   localparam logic [8:0] STEP = 9'(RAMP_STEP);

   logic [2:0]    state_q, state_d;
   logic [3:0]    speed_q, speed_d;
   logic          err_q, err_d;
   logic          trip_q, trip_d;
   logic [WW-1:0] wdog_q, wdog_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    duty_l_q, duty_l_d;
   logic [7:0]    duty_r_q, duty_r_d;
   logic          dir_l_q, dir_l_d;
   logic          dir_r_q, dir_r_d;
   logic          pwm_l_q, pwm_r_q;

   logic [7:0] up_c;
   logic       is_let, is_dig, is_crlf;
   logic [2:0] let_st;
   logic       acc, expire, tick, wrap;
   logic       tdir_l, tdir_r;
   logic [7:0] tduty;

   function automatic logic [7:0] ramp_f(input logic [7:0] cur,
                                         input logic [7:0] tgt);
      logic [8:0] diff;
      logic [7:0] res;
      res = tgt;
      if (cur < tgt) begin
         diff = {1'b0, tgt} - {1'b0, cur};
         if (diff > STEP) res = 8'({1'b0, cur} + STEP);
      end else if (cur > tgt) begin
         diff = {1'b0, cur} - {1'b0, tgt};
         if (diff > STEP) res = 8'({1'b0, cur} - STEP);
      end
      return res;
   endfunction

   // Fold lower-case letters onto upper case before decoding.
   assign up_c = (rx_data >= 8'h61 && rx_data <= 8'h7A) ?
                 rx_data - 8'h20 : rx_data;
   assign is_dig  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_crlf = (rx_data == 8'h0D) || (rx_data == 8'h0A);

   always_comb begin
      is_let = 1'b1;
      let_st = ST_STOP;
      case (up_c)
         8'h46:   let_st = ST_FWD;
         8'h42:   let_st = ST_REV;
         8'h4C:   let_st = ST_LEFT;
         8'h52:   let_st = ST_RIGHT;
         8'h53:   let_st = ST_STOP;
         default: is_let = 1'b0;
      endcase
   end

   assign acc    = rx_data_rdy & (is_let | is_dig);
   assign expire = ~acc & (state_q != ST_STOP) &
                   (wdog_q == WW'(WDOG_CYC - 1));

   always_comb begin
      state_d = state_q;
      speed_d = speed_q;
      wdog_d  = wdog_q;
      err_d   = rx_data_rdy & ~(is_let | is_dig | is_crlf);
      trip_d  = 1'b0;
      if (acc) begin
         wdog_d = '0;
         if (is_let) state_d = let_st;
         else        speed_d = rx_data[3:0];
      end else if (expire) begin
         state_d = ST_STOP;
         trip_d  = 1'b1;
         wdog_d  = '0;
      end else if (state_q == ST_STOP) begin
         wdog_d = '0;
      end else begin
         wdog_d = wdog_q + 1'b1;
      end
   end

   assign tick    = (presc_q == PW'(PWM_DIV - 1));
   assign presc_d = tick ? '0 : presc_q + 1'b1;
   assign cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
   assign wrap    = tick & (cnt_q == 8'hFF);

   always_comb begin
      tdir_l = dir_l_q;
      tdir_r = dir_r_q;
      tduty  = 8'(speed_q * 5'd28);
      case (state_q)
         ST_FWD:   begin tdir_l = 1'b1; tdir_r = 1'b1; end
         ST_REV:   begin tdir_l = 1'b0; tdir_r = 1'b0; end
         ST_LEFT:  begin tdir_l = 1'b0; tdir_r = 1'b1; end
         ST_RIGHT: begin tdir_l = 1'b1; tdir_r = 1'b0; end
         default:  tduty = 8'd0;
      endcase
   end

   // Reversal ramps to zero first; the flip lands on an idle period.
   always_comb begin
      duty_l_d = duty_l_q;
      duty_r_d = duty_r_q;
      dir_l_d  = dir_l_q;
      dir_r_d  = dir_r_q;
      if (wrap) begin
         if (tdir_l != dir_l_q) begin
            if (duty_l_q == 8'd0) dir_l_d  = tdir_l;
            else                  duty_l_d = ramp_f(duty_l_q, 8'd0);
         end else begin
            duty_l_d = ramp_f(duty_l_q, tduty);
         end
         if (tdir_r != dir_r_q) begin
            if (duty_r_q == 8'd0) dir_r_d  = tdir_r;
            else                  duty_r_d = ramp_f(duty_r_q, 8'd0);
         end else begin
            duty_r_d = ramp_f(duty_r_q, tduty);
         end
      end
   end

   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n) begin
         state_q  <= ST_STOP;
         speed_q  <= 4'(DEF_SPEED);
         err_q    <= 1'b0;
         trip_q   <= 1'b0;
         wdog_q   <= '0;
         presc_q  <= '0;
         cnt_q    <= '0;
         duty_l_q <= '0;
         duty_r_q <= '0;
         dir_l_q  <= 1'b1;
         dir_r_q  <= 1'b1;
         pwm_l_q  <= 1'b0;
         pwm_r_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         speed_q  <= speed_d;
         err_q    <= err_d;
         trip_q   <= trip_d;
         wdog_q   <= wdog_d;
         presc_q  <= presc_d;
         cnt_q    <= cnt_d;
         duty_l_q <= duty_l_d;
         duty_r_q <= duty_r_d;
         dir_l_q  <= dir_l_d;
         dir_r_q  <= dir_r_d;
         pwm_l_q  <= (cnt_q < duty_l_q);
         pwm_r_q  <= (cnt_q < duty_r_q);
      end
   end

   assign mot_l_pwm = pwm_l_q;
   assign mot_r_pwm = pwm_r_q;
   assign mot_l_dir = dir_l_q;
   assign mot_r_dir = dir_r_q;
   assign drv_state = state_q;
   assign cur_speed = speed_q;
   assign cmd_err   = err_q;
   assign wdog_trip = trip_q;

`ifdef CAR_ECHO_EN
   logic       echo_v_q, echo_v_d;
   logic [7:0] echo_c_q, echo_c_d;

   always_comb begin
      echo_v_d = echo_v_q;
      echo_c_d = echo_c_q;
      if (acc) begin
         echo_v_d = 1'b1;
         echo_c_d = up_c;
      end else if (echo_v_q && !char_fifo_full) begin
         echo_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n) begin
         echo_v_q <= 1'b0;
         echo_c_q <= '0;
      end else begin
         echo_v_q <= echo_v_d;
         echo_c_q <= echo_c_d;
      end
   end

   assign send_char_val = echo_v_q & ~char_fifo_full;
   assign send_char     = echo_c_q;
`else
   logic unused_full;
   assign unused_full   = char_fifo_full;
   assign send_char_val = 1'b0;
   assign send_char     = 8'd0;
`endif

endmodule

// File: tb/tb_car_drive_ctl.sv
// Directed self-checking bench for car_drive_ctl.
// Define CAR_ECHO_EN to also exercise the echo path.
module tb_car_drive_ctl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_rdy;
   logic       fifo_full;
   logic       l_pwm, l_dir, r_pwm, r_dir;
   logic [2:0] state;
   logic [3:0] speed;
   logic       err, trip, sc_val;
   logic [7:0] sc;

   int checks = 0;
   int errors = 0;
   int err_n  = 0;
   int trip_n = 0;
   int glitch = 0;
   int echo_n = 0;
   int echo_last = 0;
   int hl, hr, snap;
   logic pl = 0, pr = 0, dl = 1, dr = 1;

   car_drive_ctl #(
      .PWM_DIV(1), .RAMP_STEP(28), .WDOG_CYC(3000), .DEF_SPEED(5)
   ) dut (
      .clk_rx(clk), .rst_clk_rx_n(rst_n),
      .rx_data(rx_data), .rx_data_rdy(rx_rdy),
      .char_fifo_full(fifo_full),
      .mot_l_pwm(l_pwm), .mot_l_dir(l_dir),
      .mot_r_pwm(r_pwm), .mot_r_dir(r_dir),
      .drv_state(state), .cur_speed(speed),
      .cmd_err(err), .wdog_trip(trip),
      .send_char_val(sc_val), .send_char(sc)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (err) err_n++;
         if (trip) trip_n++;
         if (sc_val) begin
            echo_n++;
            echo_last = int'(sc);
         end
         if ((l_dir != dl) && (l_pwm || pl)) glitch++;
         if ((r_dir != dr) && (r_pwm || pr)) glitch++;
      end
      pl = l_pwm; pr = r_pwm; dl = l_dir; dr = r_dir;
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] c);
      rx_data = c;
      rx_rdy  = 1'b1;
      @(negedge clk);
      rx_rdy  = 1'b0;
      rx_data = 8'd0;
   endtask

   task automatic keep(input int periods, input logic [7:0] dig);
      for (int i = 0; i < periods; i++) begin
         repeat (256) @(negedge clk);
         send(dig);
      end
   endtask

   task automatic meas(output int nl, output int nr);
      nl = 0;
      nr = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         nl += int'(l_pwm);
         nr += int'(r_pwm);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rx_data = 8'd0;
      rx_rdy = 1'b0;
      fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state", int'(state), 0);
      chk("rst_speed", int'(speed), 5);
      chk("rst_lpwm", int'(l_pwm), 0);
      chk("rst_ldir", int'(l_dir), 1);
      chk("rst_rdir", int'(r_dir), 1);
      rst_n = 1'b1;
      @(negedge clk);

      send("7");
      send("F");
      chk("t1_state", int'(state), 1);
      chk("t1_speed", int'(speed), 7);
      keep(10, "7");
      meas(hl, hr);
      chk("t1_hl", hl, 196);
      chk("t1_hr", hr, 196);
      chk("t1_dirs", int'({l_dir, r_dir}), 3);

      send("B");
      repeat (300) @(negedge clk);
      chk("t2_dir_held", int'(l_dir), 1);
      keep(16, "7");
      meas(hl, hr);
      chk("t2_state", int'(state), 2);
      chk("t2_dirs", int'({l_dir, r_dir}), 0);
      chk("t2_hl", hl, 196);
      chk("t2_hr", hr, 196);

      send("3");
      send("l");
      chk("t3_state", int'(state), 3);
      keep(20, "3");
      meas(hl, hr);
      chk("t3_ldir", int'(l_dir), 0);
      chk("t3_rdir", int'(r_dir), 1);
      chk("t3_hl", hl, 84);
      chk("t3_hr", hr, 84);
      chk("t3_glitch", glitch, 0);

      err_n = 0;
      send("X");
      send(8'h0D);
      repeat (3) @(negedge clk);
      chk("t4_err", err_n, 1);
      chk("t4_state", int'(state), 3);
      chk("t4_speed", int'(speed), 3);

      chk("t5_notrip", trip_n, 0);
      send("F");
      repeat (3005) @(negedge clk);
      chk("t5_trip", trip_n, 1);
      chk("t5_state", int'(state), 0);
      repeat (2560) @(negedge clk);
      meas(hl, hr);
      chk("t5_hl", hl, 0);
      chk("t5_hr", hr, 0);
      snap = trip_n;
      send("F");
      repeat (2999) @(negedge clk);
      send("S");
      repeat (20) @(negedge clk);
      chk("t5_race", trip_n, snap);
      chk("t5_state2", int'(state), 0);

`ifdef CAR_ECHO_EN
      repeat (4) @(negedge clk);
      echo_n = 0;
      fifo_full = 1'b1;
      send("f");
      send("2");
      repeat (5) @(negedge clk);
      chk("t6_held", echo_n, 0);
      fifo_full = 1'b0;
      repeat (5) @(negedge clk);
      chk("t6_cnt", echo_n, 1);
      chk("t6_char", echo_last, 8'h32);
`else
      chk("t6_noecho", echo_n, 0);
      chk("t6_char0", int'(sc), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
